// File: rtl/pulse_emitter.sv
// pulse_emitter -- test-pulse burst transmitter.
//
// Emits bursts of clean pulses with a programmable high width, low gap and
// pulse count. pulse_out is registered and feeds the OBUFDS at the top level.
//
// Ports:
//   clk         system clock (100 MHz)
//   rst         asynchronous active-high reset
//   start       burst request, sampled only in IDLE
//   abort       terminate the current burst (no done strobe)
//   burst_len   pulses per burst (latched at start)
//   width_cyc   high time in clk cycles (latched at start, 0 treated as 1)
//   gap_cyc     low time in clk cycles (latched at start, 0 treated as 1)
//   pulse_out   registered pulse output
//   busy        high while a burst is in progress
//   done        one-cycle strobe on normal burst completion
//   pulse_count total pulses emitted since reset (wraps)
//
// Optional build macro: PULSE_EMITTER_RANDOM_GAP_EN adds a 16-bit LFSR that
// stretches every gap by (lfsr & GAP_MASK) to mimic random arrival times.

module pulse_emitter #(
  parameter int          CNT_W    = 16,
  parameter int          TIME_W   = 32,
  parameter logic [15:0] GAP_MASK = 16'h00FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [TIME_W-1:0] width_cyc,
  input  logic [TIME_W-1:0] gap_cyc,
  output logic              pulse_out,
  output logic              busy,
  output logic              done,
  output logic [31:0]       pulse_count
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t            state_q, state_d;
  logic [TIME_W-1:0] phase_q, phase_d;    // cycles left in current phase, minus 1
  logic [CNT_W-1:0]  remain_q, remain_d;  // pulses left, including the current one
  logic [TIME_W-1:0] width_q, width_d;
  logic [TIME_W-1:0] gap_q, gap_d;        // gap length for the next LOW phase
  logic              pulse_d, busy_d, done_d;
  logic [31:0]       count_d;

  logic [TIME_W-1:0] width_c, gap_c;

  assign width_c = (width_cyc == '0) ? TIME_W'(1) : width_cyc;
  assign gap_c   = (gap_cyc   == '0) ? TIME_W'(1) : gap_cyc;

`ifdef PULSE_EMITTER_RANDOM_GAP_EN
  logic [15:0]       lfsr_q, lfsr_d, lfsr_next;
  logic [TIME_W-1:0] base_gap_q, base_gap_d;
  logic [TIME_W-1:0] gap_base;
  logic [TIME_W:0]   gap_sum;
  logic [TIME_W-1:0] gap_rand;

  // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
  assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  // Gap for the pulse being entered uses the LFSR value before it advances.
  // The sum is one bit wider so a carry saturates instead of wrapping.
  assign gap_base = (state_q == S_IDLE) ? gap_c : base_gap_q;
  assign gap_sum  = {1'b0, gap_base} + (TIME_W+1)'(lfsr_q & GAP_MASK);
  assign gap_rand = gap_sum[TIME_W] ? {TIME_W{1'b1}} : gap_sum[TIME_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      remain_q    <= '0;
      width_q     <= '0;
      gap_q       <= '0;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulse_count <= '0;
`ifdef PULSE_EMITTER_RANDOM_GAP_EN
      lfsr_q      <= 16'hACE1;
      base_gap_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      remain_q    <= remain_d;
      width_q     <= width_d;
      gap_q       <= gap_d;
      pulse_out   <= pulse_d;
      busy        <= busy_d;
      done        <= done_d;
      pulse_count <= count_d;
`ifdef PULSE_EMITTER_RANDOM_GAP_EN
      lfsr_q      <= lfsr_d;
      base_gap_q  <= base_gap_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    width_d  = width_q;
    gap_d    = gap_q;
    pulse_d  = pulse_out;
    busy_d   = busy;
    done_d   = 1'b0;
    count_d  = pulse_count;
`ifdef PULSE_EMITTER_RANDOM_GAP_EN
    lfsr_d     = lfsr_q;
    base_gap_d = base_gap_q;
`endif

    case (state_q)
      S_IDLE: begin
        // abort in IDLE only serves to drop a coincident start
        if (start && !abort) begin
          if (burst_len != '0) begin
            state_d  = S_HIGH;
            pulse_d  = 1'b1;
            busy_d   = 1'b1;
            count_d  = pulse_count + 32'd1;
            phase_d  = width_c - TIME_W'(1);
            width_d  = width_c;
            remain_d = burst_len;
`ifdef PULSE_EMITTER_RANDOM_GAP_EN
            base_gap_d = gap_c;
            gap_d      = gap_rand;
            lfsr_d     = lfsr_next;
`else
            gap_d      = gap_c;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_HIGH: begin
        if (abort) begin
          state_d = S_IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
        end else if (phase_q == '0) begin
          pulse_d = 1'b0;
          if (remain_q > CNT_W'(1)) begin
            state_d = S_LOW;
            phase_d = gap_q - TIME_W'(1);
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q - TIME_W'(1);
        end
      end

      S_LOW: begin
        if (abort) begin
          state_d = S_IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
        end else if (phase_q == '0) begin
          state_d  = S_HIGH;
          pulse_d  = 1'b1;
          count_d  = pulse_count + 32'd1;
          remain_d = remain_q - CNT_W'(1);
          phase_d  = width_q - TIME_W'(1);
`ifdef PULSE_EMITTER_RANDOM_GAP_EN
          gap_d    = gap_rand;
          lfsr_d   = lfsr_next;
`endif
        end else begin
          phase_d = phase_q - TIME_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_emitter.sv
// Directed bench for pulse_emitter (default build, fixed gaps).
module tb_pulse_emitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] burst_len = '0;
  logic [31:0] width_cyc = '0;
  logic [31:0] gap_cyc = '0;
  logic        pulse_out, busy, done;
  logic [31:0] pulse_count;

  int n_pass = 0;
  int n_total = 0;

  pulse_emitter #(.CNT_W(16), .TIME_W(32), .GAP_MASK(16'h00FF)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .burst_len(burst_len), .width_cyc(width_cyc), .gap_cyc(gap_cyc),
    .pulse_out(pulse_out), .busy(busy), .done(done), .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Start a burst: inputs set after an edge, accepted at the next edge.
  // On return the outputs show cycle N+1.
  task automatic go(input logic [15:0] b, input logic [31:0] w, input logic [31:0] g);
    burst_len = b; width_cyc = w; gap_cyc = g; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pulse", 32'(pulse_out), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_count", pulse_count, 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();

    // B=4 W=3 G=2: high at 1..3, 6..8, 11..13, 16..18; done at 19
    go(16'd4, 32'd3, 32'd2);
    for (int i = 1; i <= 19; i++) begin
      if (i > 1) tick();
      check($sformatf("b4_pulse_c%0d", i), 32'(pulse_out),
            32'((i <= 18) && (((i - 1) % 5) < 3)));
      if (i == 18) begin
        check("b4_busy_c18", 32'(busy), 32'd1);
        check("b4_done_c18", 32'(done), 32'd0);
      end
    end
    check("b4_done_c19", 32'(done), 32'd1);
    check("b4_busy_c19", 32'(busy), 32'd0);
    check("b4_count",    pulse_count, 32'd4);
    tick();
    check("b4_done_c20", 32'(done), 32'd0);

    // burst_len=0: done next cycle, no pulse, no busy
    go(16'd0, 32'd3, 32'd2);
    check("b0_done",  32'(done), 32'd1);
    check("b0_busy",  32'(busy), 32'd0);
    check("b0_pulse", 32'(pulse_out), 32'd0);
    tick();
    check("b0_done_off", 32'(done), 32'd0);
    check("b0_count",    pulse_count, 32'd4);

    // W=0 G=0 clamp to 1: 1,0,1,0,1 then done
    go(16'd3, 32'd0, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) tick();
      check($sformatf("clamp_pulse_c%0d", i), 32'(pulse_out), 32'(i % 2));
    end
    tick();
    check("clamp_done",  32'(done), 32'd1);
    check("clamp_pulse", 32'(pulse_out), 32'd0);
    check("clamp_count", pulse_count, 32'd7);
    tick();

    // start and abort together in IDLE: abort wins
    burst_len = 16'd2; width_cyc = 32'd2; gap_cyc = 32'd2;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_busy",  32'(busy), 32'd0);
    check("sa_pulse", 32'(pulse_out), 32'd0);
    check("sa_count", pulse_count, 32'd7);
    tick();

    // B=10 W=5 G=5, ignored restart and input changes, abort in 3rd pulse
    go(16'd10, 32'd5, 32'd5);
    check("ab_c1_pulse", 32'(pulse_out), 32'd1);
    for (int i = 2; i <= 22; i++) begin
      if (i == 7) begin
        start = 1'b1; burst_len = 16'd1; width_cyc = 32'd1; gap_cyc = 32'd9;
      end
      if (i == 8) start = 1'b0;
      tick();
      if (i == 10) check("ab_c10_pulse", 32'(pulse_out), 32'd0);
      if (i == 11) begin
        check("ab_c11_pulse", 32'(pulse_out), 32'd1);
        check("ab_c11_count", pulse_count, 32'd9);
      end
      if (i == 16) check("ab_c16_pulse", 32'(pulse_out), 32'd0);
    end
    check("ab_c22_pulse", 32'(pulse_out), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_pulse", 32'(pulse_out), 32'd0);
    check("ab_busy",  32'(busy), 32'd0);
    check("ab_done",  32'(done), 32'd0);
    check("ab_count", pulse_count, 32'd10);
    tick();
    check("ab_done_next",  32'(done), 32'd0);
    check("ab_pulse_next", 32'(pulse_out), 32'd0);

    // counter wrap
    force dut.pulse_count = 32'hFFFF_FFFE;
    tick();
    release dut.pulse_count;
    tick();
    check("wrap_preset", pulse_count, 32'hFFFF_FFFE);
    go(16'd3, 32'd1, 32'd1);
    check("wrap_c1", pulse_count, 32'hFFFF_FFFF);
    tick(); tick();
    check("wrap_c3", pulse_count, 32'h0000_0000);
    tick(); tick(); tick();
    check("wrap_done",  32'(done), 32'd1);
    check("wrap_count", pulse_count, 32'h0000_0001);

    // reset mid-pulse acts immediately
    go(16'd5, 32'd4, 32'd1);
    tick();
    check("mid_pulse_hi", 32'(pulse_out), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_pulse", 32'(pulse_out), 32'd0);
    check("mid_rst_count", pulse_count, 32'd0);
    check("mid_rst_busy",  32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();

    // first burst after reset
    go(16'd1, 32'd2, 32'd3);
    check("post_c1_pulse", 32'(pulse_out), 32'd1);
    check("post_c1_count", pulse_count, 32'd1);
    tick();
    check("post_c2_pulse", 32'(pulse_out), 32'd1);
    tick();
    check("post_c3_pulse", 32'(pulse_out), 32'd0);
    check("post_c3_done",  32'(done), 32'd1);
    check("post_c3_busy",  32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pulse_emitter.md
Name: pulse_emitter

Overview:
- Test-pulse transmitter: generates bursts of clean digital pulses with programmable high width, low gap and count.
- Drives the FPGA's differential LVDS output pair through an OBUFDS at the top level. The output is looped back to, or cabled into, the pulse-capture/LED path.
- Provides known stimulus for bench and board-level characterisation of the muon-daq front end at 100 MHz.

Parameters:
- CNT_W, 16: width of the burst_len input and the internal pulse-remaining counter.
- TIME_W, 32: width of the width_cyc and gap_cyc inputs and the internal phase counter.
- GAP_MASK, 16'h00FF: mask applied to LFSR bits for the random gap extension (used only with the optional feature).

Ports:
- clk, input, 1: system clock, 100 MHz from the clock wizard.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: burst request; sampled only in IDLE.
- abort, input, 1: terminates the current burst.
- burst_len, input, CNT_W: number of pulses in the burst.
- width_cyc, input, TIME_W: high time in clk cycles.
- gap_cyc, input, TIME_W: low time between pulses in clk cycles.
- pulse_out, output, 1: registered pulse to the OBUFDS.
- busy, output, 1: high while a burst is in progress.
- done, output, 1: one-cycle strobe when a burst completes normally.
- pulse_count, output, 32: total pulses emitted since reset.

Behaviour:
- Reset (async assert, sync release): state=IDLE; pulse_out=0, busy=0, done=0, pulse_count=0; LFSR=16'hACE1.
- Configuration latching:
  - burst_len, width_cyc and gap_cyc are latched on the accepted start cycle.
  - Input changes during a burst have no effect.
- Clamping: width_cyc=0 is treated as 1; gap_cyc=0 is treated as 1. This guarantees at least one low cycle between pulses so a downstream rising-edge detector sees every pulse.
- State machine, all outputs registered:
  - IDLE:
    - start=1 and burst_len>0 -> HIGH. Next cycle: pulse_out=1, busy=1, pulse_count+1.
    - start=1 and burst_len=0 -> stay IDLE. done=1 for one cycle next cycle; busy stays 0.
  - HIGH:
    - pulse_out stays 1 for exactly width cycles.
    - On the last high cycle, if pulses remaining>1 -> LOW.
    - If this is the last pulse -> IDLE. Next cycle: pulse_out=0, busy=0, done=1.
  - LOW:
    - pulse_out stays 0 for exactly gap cycles, then -> HIGH.
    - Next cycle: pulse_out=1, pulse_count+1, remaining-1.
- Latency: start accepted at cycle N -> first rising edge of pulse_out at N+1.
- Burst length:
  - Last falling edge at N+1 + B*W + (B-1)*G.
  - done is asserted in that same cycle.
  - No trailing gap is inserted.
- start while busy: ignored. No queuing, no error flag.
- abort:
  - In HIGH or LOW: next cycle pulse_out=0, busy=0, state=IDLE; done is not asserted.
  - A pulse truncated by abort remains counted in pulse_count.
  - abort in IDLE: no effect.
- Simultaneous start and abort in IDLE: abort wins; start is dropped.
- pulse_count:
  - Increments on every rising edge of pulse_out.
  - Wraps from 32'hFFFF_FFFF to 0 silently.
- Width rules:
  - The phase counter counts down from the latched value minus 1 and does not overflow.
  - With LFSR gap extension, the effective gap is computed in TIME_W+1 bits and saturates at 2^TIME_W-1.
- Reset mid-burst: immediate return to reset values. A subsequent start behaves as the first burst.

Optional Feature:
- Macro: PULSE_EMITTER_RANDOM_GAP_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances once per emitted pulse, on each IDLE/LOW->HIGH transition.
  - Effective gap = clamped gap_cyc + (lfsr & GAP_MASK), using the LFSR value before the advance.
  - Models random muon arrival times.
  - The LFSR is reset only by rst; it is not reset by start or abort.
- Undefined:
  - No LFSR logic is present.
  - Gap is exactly the clamped gap_cyc.

Test Plan:
- Reset, then start with burst_len=4, width_cyc=3, gap_cyc=2 -> pulse_out high cycles N+1..N+3, N+6..N+8, N+11..N+13, N+16..N+18; done at N+19; pulse_count=4; busy low at N+19.
- burst_len=0 start -> no pulse, done strobe one cycle later, busy never asserted, pulse_count unchanged.
- width_cyc=0, gap_cyc=0, burst_len=3 -> alternating 1,0,1,0,1 pattern; done on the cycle after the third high; pulse_count=3.
- burst_len=10, width 5, gap 5; abort during the 3rd pulse's high phase -> pulse_out 0 next cycle, busy 0, no done, pulse_count=3. Start re-pulsed during the burst is ignored.
- Force pulse_count to 32'hFFFF_FFFE, then burst_len=3 -> count ends at 32'h0000_0001. Assert rst mid-pulse -> pulse_out=0 immediately, count=0.
- With PULSE_EMITTER_RANDOM_GAP_EN, burst_len=2, width 1, gap 1 -> first gap = 1 + (16'hACE1 & 8'hFF) = 226 cycles; compare against the reference LFSR model.
